// File: rtl/ifu_prefetch.sv
`default_nettype none
// ifu_prefetch: sequential fetch PC generator feeding a DEPTH-entry {pc, inst} prefetch queue.
// Optional feature macro IFU_ALIGN_CHK_EN: flags misaligned redirect targets (align_err) and stalls fetch.
module ifu_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef IFU_ALIGN_CHK_EN
  ,
  output logic              align_err
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        cur_state;
  logic [1:0]        next_state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [ADDR_W-1:0] target;
  logic              inflight;
  logic              align_hold;
  logic              target_bad;
  logic              flush;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_next;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

`ifdef IFU_ALIGN_CHK_EN
  logic align_q;

  assign target_bad = |redirect_addr[1:0];
  assign target     = redirect_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      align_q <= 1'b0;
    end else if (redirect_valid) begin
      align_q <= target_bad;
    end
  end

  assign align_hold = align_q;
  assign align_err  = align_q;
`else
  assign target_bad = 1'b0;
  assign align_hold = 1'b0;
  assign target     = redirect_addr & ~ADDR_W'(3);
`endif

  // A redirect is the flush cycle itself, so the target can issue on the very next cycle.
  assign flush     = redirect_valid;
  assign cur_state = flush ? S_FLUSH : state_q;

  assign inst_valid = (cnt != '0);
  assign pop        = inst_valid && inst_ready;
  assign push       = inflight && !flush;
  assign occ        = OCC_W'(cnt) + OCC_W'(inflight);
  assign occ_next   = occ + OCC_W'(rom_ce) - OCC_W'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= next_state;
    end
  end

  always_comb begin
    next_state = state_q;
    case (cur_state)
      S_FLUSH: next_state = target_bad ? S_HOLD : S_RUN;
      S_RUN:   next_state = (occ_next >= OCC_W'(DEPTH)) ? S_HOLD : S_RUN;
      S_HOLD: begin
        if (pop && !align_hold) begin
          next_state = S_RUN;
        end
      end
      default: next_state = S_RUN;
    endcase
  end

  // rst gates rom_ce directly so the first read goes out in the first cycle after release.
  always_comb begin
    rom_ce    = 1'b0;
    rom_addr  = fetch_pc;
    inst_data = '0;
    inst_pc   = '0;
    if (rst && (cur_state == S_RUN) && (occ < OCC_W'(DEPTH))) begin
      rom_ce = 1'b1;
    end
    if (inst_valid) begin
      inst_data = data_mem[rd_ptr];
      inst_pc   = pc_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
    end else begin
      inflight <= rom_ce;
      if (rom_ce) begin
        inflight_pc <= fetch_pc;
      end
      if (flush) begin
        fetch_pc <= target;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        cnt      <= '0;
      end else begin
        if (rom_ce) begin
          fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          cnt <= cnt + CNT_W'(1);
        end else if (pop && !push) begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= rom_data;
      pc_mem[wr_ptr]   <= inflight_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// tb_ifu_prefetch: directed checks of fetch latency, stall, streaming, redirect, wrap and reset.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef IFU_ALIGN_CHK_EN
  logic        align_err;
`endif

  int checks = 0;
  int failures = 0;

  ifu_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef IFU_ALIGN_CHK_EN
    ,
    .align_err      (align_err)
`endif
  );

  always #5 clk = ~clk;

  // ROM returns its own address as the instruction word, one cycle after rom_ce.
  always @(posedge clk) begin
    if (rom_ce) rom_data <= rom_addr;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the caller at posedge+1 of the first cycle with rst=1.
  task automatic do_reset(input logic ready);
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    inst_ready = ready;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_ready = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL reset_rom_ce got=%0b exp=0", rom_ce); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%0b exp=0", inst_valid); end
    checks++; if (inst_data !== 32'h0) begin failures++; $display("FAIL reset_inst_data got=%h exp=0", inst_data); end
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_inst_pc got=%h exp=0", inst_pc); end
`ifdef IFU_ALIGN_CHK_EN
    checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL reset_align_err got=%0b exp=0", align_err); end
`endif
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) next_cycle();
      #1;
      checks++;
      if (rom_ce !== 1'b1 || rom_addr !== 32'(4 * (k - 1))) begin
        failures++; $display("FAIL stream_rom cyc=%0d got ce=%0b addr=%h exp ce=1 addr=%h", k, rom_ce, rom_addr, 32'(4 * (k - 1)));
      end
      checks++;
      if (k < 3) begin
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_early_valid cyc=%0d got=%0b exp=0", k, inst_valid); end
      end else if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 3)) || inst_data !== 32'(4 * (k - 3))) begin
        failures++; $display("FAIL stream_head cyc=%0d got v=%0b pc=%h d=%h exp pc=%h", k, inst_valid, inst_pc, inst_data, 32'(4 * (k - 3)));
      end
    end
  endtask

  task automatic test_stall();
    int issued;
    int n;
    logic [31:0] last_addr;
    issued = 0;
    last_addr = '1;
    do_reset(1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) next_cycle();
      #1;
      if (rom_ce) begin issued++; last_addr = rom_addr; end
      if (k >= 3) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
          failures++; $display("FAIL stall_head cyc=%0d got v=%0b pc=%h exp v=1 pc=0", k, inst_valid, inst_pc);
        end
      end
    end
    checks++; if (issued != 4) begin failures++; $display("FAIL stall_issue_count got=%0d exp=4", issued); end
    checks++; if (last_addr !== 32'hC) begin failures++; $display("FAIL stall_last_addr got=%h exp=c", last_addr); end
    checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL stall_hold_ce got=%0b exp=0", rom_ce); end
    next_cycle();
    inst_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 5; k++) begin
      if (k > 0) next_cycle();
      #1;
      if (inst_valid) begin
        checks++;
        if (inst_pc !== 32'(4 * n)) begin failures++; $display("FAIL stall_drain idx=%0d got=%h exp=%h", n, inst_pc, 32'(4 * n)); end
        n++;
      end
    end
    checks++; if (n != 5) begin failures++; $display("FAIL stall_drain_timeout got=%0d exp=5", n); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    for (int k = 1; k <= 11; k++) next_cycle();
    inst_ready = 1'b1;
    exp_pc = 32'h0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) next_cycle();
      #1;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst_data !== exp_pc) begin
        failures++; $display("FAIL b2b_head step=%0d got v=%0b pc=%h d=%h exp pc=%h", k, inst_valid, inst_pc, inst_data, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b1);
    for (int k = 2; k <= 7; k++) next_cycle();
    redirect_valid = 1'b1; redirect_addr = 32'h100;
    #1;
    checks++; if (rom_ce !== 1'b0 || inst_valid !== 1'b1) begin failures++; $display("FAIL redir_req got ce=%0b v=%0b exp ce=0 v=1", rom_ce, inst_valid); end
    next_cycle(); redirect_valid = 1'b0; #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h100 || inst_valid !== 1'b0) begin failures++; $display("FAIL redir_r1 got ce=%0b addr=%h v=%0b exp 1/100/0", rom_ce, rom_addr, inst_valid); end
    next_cycle(); #1;
    checks++; if (inst_valid !== 1'b0 || rom_addr !== 32'h104) begin failures++; $display("FAIL redir_r2 got v=%0b addr=%h exp 0/104", inst_valid, rom_addr); end
    next_cycle(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h100) begin failures++; $display("FAIL redir_r3 got v=%0b pc=%h d=%h exp 1/100/100", inst_valid, inst_pc, inst_data); end
    next_cycle(); #1;
    checks++; if (inst_pc !== 32'h104) begin failures++; $display("FAIL redir_r4 got pc=%h exp=104", inst_pc); end
    // Held redirect: last target wins, and the PC then wraps through zero.
    next_cycle(); redirect_valid = 1'b1; redirect_addr = 32'h300; #1;
    next_cycle(); redirect_addr = 32'h400; #1;
    checks++; if (rom_ce !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL redir_held got ce=%0b v=%0b exp 0/0", rom_ce, inst_valid); end
    next_cycle(); redirect_addr = 32'hFFFF_FFF8; #1;
    next_cycle(); redirect_valid = 1'b0; #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL redir_last got ce=%0b addr=%h exp 1/fffffff8", rom_ce, rom_addr); end
    next_cycle(); next_cycle(); #1;
    checks++; if (rom_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_a got addr=%h pc=%h exp 0/fffffff8", rom_addr, inst_pc); end
    next_cycle(); #1;
    checks++; if (inst_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_b got pc=%h exp=fffffffc", inst_pc); end
    next_cycle(); #1;
    checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL wrap_c got pc=%h exp=0", inst_pc); end
`ifndef IFU_ALIGN_CHK_EN
    next_cycle(); redirect_valid = 1'b1; redirect_addr = 32'h102; #1;
    next_cycle(); redirect_valid = 1'b0; #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h100) begin failures++; $display("FAIL redir_forced_align got ce=%0b addr=%h exp 1/100", rom_ce, rom_addr); end
`endif
  endtask

`ifdef IFU_ALIGN_CHK_EN
  task automatic test_align();
    do_reset(1'b1);
    for (int k = 2; k <= 5; k++) next_cycle();
    redirect_valid = 1'b1; redirect_addr = 32'h102;
    next_cycle(); redirect_valid = 1'b0; #1;
    checks++; if (align_err !== 1'b1) begin failures++; $display("FAIL align_set got=%0b exp=1", align_err); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin next_cycle(); #1; end
      checks++;
      if (rom_ce !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL align_stall step=%0d got ce=%0b v=%0b exp 0/0", k, rom_ce, inst_valid); end
    end
    next_cycle(); redirect_valid = 1'b1; redirect_addr = 32'h200;
    next_cycle(); redirect_valid = 1'b0; #1;
    checks++; if (align_err !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h200) begin failures++; $display("FAIL align_clear got err=%0b ce=%0b addr=%h exp 0/1/200", align_err, rom_ce, rom_addr); end
  endtask
`endif

  task automatic test_mid_reset();
    do_reset(1'b1);
    for (int k = 2; k <= 6; k++) next_cycle();
    #1;
    checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL mrst_pre got v=%0b exp=1", inst_valid); end
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (rom_ce !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin
      failures++; $display("FAIL mrst_async got ce=%0b v=%0b pc=%h d=%h exp all 0", rom_ce, inst_valid, inst_pc, inst_data);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0 || inst_valid !== 1'b0) begin failures++; $display("FAIL mrst_restart got ce=%0b addr=%h v=%0b exp 1/0/0", rom_ce, rom_addr, inst_valid); end
    next_cycle(); next_cycle(); #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL mrst_head got v=%0b pc=%h exp 1/0", inst_valid, inst_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_redirect();
`ifdef IFU_ALIGN_CHK_EN
    test_align();
`endif
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
